orao_tape_sched: RTL



---
 rtl/orao_tape_pkg.sv | 17 +
 rtl/orao_tape_sched_if.sv | 23 ++
 rtl/orao_tape_fifo.sv | 42 ++++
 rtl/orao_tape_sched.sv | 129 ++++++++++++
 4 files changed

// File: rtl/orao_tape_pkg.sv
// Shared types and constants for the Orao tape playback scheduler.
// ORAO_TAPE_SCHMITT_EN selects the hysteresis thresholds in orao_tape_sched.
package orao_tape_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, DRAIN, ABORT} state_t;

   localparam logic [15:0] TAPE_ADDR  = 16'h87FF;
   localparam logic [7:0]  THRESH_MID = 8'h7F;
   localparam logic [7:0]  THRESH_HI  = 8'hA0;
   localparam logic [7:0]  THRESH_LO  = 8'h5F;

   localparam int ST_EMPTY    = 0;
   localparam int ST_OVERFLOW = 1;
   localparam int ST_UNDERRUN = 2;
   localparam int ST_TIMEOUT  = 3;

endpackage

// File: rtl/orao_tape_sched_if.sv
// ioctl download bus plus CPU read port of the tape scheduler.
interface orao_tape_sched_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [15:0] addr;
   logic        ce;
   logic [7:0]  tape_data;
   logic        tape_active;
   logic [3:0]  status;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, addr, ce,
      input  ioctl_wait, tape_data, tape_active, status
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, addr, ce,
      output ioctl_wait, tape_data, tape_active, status
   );
endinterface

// File: rtl/orao_tape_fifo.sv
// Show-ahead byte FIFO with flush; pushes while full and pops while empty are ignored.
module orao_tape_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic        do_push, do_pop;

   assign count   = wptr - rptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr[AW-1:0]];

   // Extra pointer bit distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && !flush && do_push) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/orao_tape_sched.sv
// Tape playback scheduler: buffers HPS tape bytes, paces samples to 0x87FF reads.
// Define ORAO_TAPE_SCHMITT_EN for hysteresis thresholding of output samples.
module orao_tape_sched
   import orao_tape_pkg::*;
#(
   parameter int          FIFO_DEPTH       = 16,
   parameter int          PRIME_LEVEL      = 4,
   parameter int          READS_PER_SAMPLE = 2,
   parameter int unsigned TIMEOUT_CYCLES   = 75000000,
   parameter logic [7:0]  TAPE_INDEX       = 8'h01
) (
   input  logic clk,
   input  logic reset_n,
   orao_tape_sched_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (READS_PER_SAMPLE > 1) ? $clog2(READS_PER_SAMPLE) : 1;
   localparam logic [PW-1:0] PACE_LAST = PW'(READS_PER_SAMPLE - 1);
   localparam logic [AW:0]   PRIME     = (AW+1)'(PRIME_LEVEL);
   localparam logic [AW:0]   WAIT_HI   = (AW+1)'(FIFO_DEPTH - 2);
   localparam logic [AW:0]   WAIT_LO   = (AW+1)'(FIFO_DEPTH / 2);
   localparam logic [31:0]   TMO_LAST  = TIMEOUT_CYCLES - 1;

   state_t        state, state_n;
   logic          tdl, tdl_q, tdl_rise, tdl_fall;
   logic          last_hit, rd_evt;
   logic [PW-1:0] pace;
   logic [31:0]   tmo;
   logic          active, pacing, tmo_hit, flush;
   logic          push_req, pop_due, pop, underrun;
   logic [7:0]    head, level_n, tape_q;
   logic [AW:0]   count;
   logic          full, empty, wait_q;
   logic          timeout_flag, underrun_flag, overflow_flag;

   assign tdl      = bus.ioctl_download && (bus.ioctl_index == TAPE_INDEX);
   assign tdl_rise = tdl && !tdl_q;
   assign tdl_fall = !tdl && tdl_q;
   assign rd_evt   = bus.ce && (bus.addr == TAPE_ADDR) && !last_hit;
   assign active   = state inside {LOAD, PLAY, DRAIN};
   assign pacing   = state inside {PLAY, DRAIN};
   assign tmo_hit  = active && (tmo >= TMO_LAST);
   assign flush    = tdl_rise || tmo_hit;
   assign push_req = bus.ioctl_wr && tdl && (state inside {LOAD, PLAY}) && !flush;
   assign pop_due  = pacing && rd_evt && (pace == PACE_LAST) && !flush;
   assign pop      = pop_due && !empty;
   assign underrun = pop_due && empty;

   orao_tape_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .push(push_req), .din(bus.ioctl_dout), .pop(pop),
      .dout(head), .count(count), .full(full), .empty(empty)
   );

   always_comb begin
      state_n = state;
      if (tdl_rise)      state_n = LOAD;
      else if (tmo_hit)  state_n = ABORT;
      else begin
         case (state)
            LOAD:    if (tdl_fall) state_n = DRAIN;
                     else if (count >= PRIME) state_n = PLAY;
            PLAY:    if (tdl_fall) state_n = DRAIN;
            DRAIN:   if (empty && !pop) state_n = IDLE;
            ABORT:   if (!tdl) state_n = IDLE;
            default: state_n = state;
         endcase
      end
   end

   always_comb begin
      level_n = tape_q;
`ifdef ORAO_TAPE_SCHMITT_EN
      if (head >= THRESH_HI)      level_n = 8'hFF;
      else if (head <= THRESH_LO) level_n = 8'h00;
`else
      level_n = (head > THRESH_MID) ? 8'hFF : 8'h00;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         tdl_q         <= 1'b0;
         last_hit      <= 1'b0;
         pace          <= '0;
         tmo           <= '0;
         wait_q        <= 1'b0;
         tape_q        <= 8'h00;
         timeout_flag  <= 1'b0;
         underrun_flag <= 1'b0;
         overflow_flag <= 1'b0;
      end else begin
         state <= state_n;
         tdl_q <= tdl;
         if (bus.ce) last_hit <= (bus.addr == TAPE_ADDR);

         if (flush)                 pace <= '0;
         else if (pacing && rd_evt) pace <= (pace == PACE_LAST) ? '0 : pace + 1'b1;

         // Any sign of life (push, read, state change) restarts the stall timer.
         if (!active || state_n != state || (push_req && !full) || rd_evt) tmo <= '0;
         else if (tmo != '1) tmo <= tmo + 32'd1;

         if (flush || (state_n inside {IDLE, ABORT})) wait_q <= 1'b0;
         else if (count >= WAIT_HI)                 wait_q <= 1'b1;
         else if (count <= WAIT_LO)                 wait_q <= 1'b0;

         if (tdl_rise)      tape_q <= 8'h00;
         else if (pop)      tape_q <= level_n;
         else if (underrun) tape_q <= 8'h00;

         if (tdl_rise) begin
            timeout_flag  <= 1'b0;
            underrun_flag <= 1'b0;
            overflow_flag <= 1'b0;
         end else begin
            if (tmo_hit)          timeout_flag  <= 1'b1;
            if (underrun)         underrun_flag <= 1'b1;
            if (push_req && full) overflow_flag <= 1'b1;
         end
      end
   end

   assign bus.ioctl_wait  = wait_q;
   assign bus.tape_data   = tape_q;
   assign bus.tape_active = active;
   assign bus.status      = {timeout_flag, underrun_flag, overflow_flag, empty};
endmodule
